// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : onehot_pkg
//  Description : Constants and types shared by the priority encoder and the
//                one-hot pulse decoder (line count, index width, counter
//                width, decoder FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_pkg;

    // Default line count and index width, shared with the priority encoder
    localparam int C_ONEHOT_N     = 8;
    localparam int C_ONEHOT_IDX_W = 3;

    // Width of the pulses-started counter
    localparam int C_SENT_CNT_W   = 16;

    // Decoder FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } dec_state_e;

endpackage : onehot_pkg
`default_nettype wire

// File: rtl/sync_fifo_idx.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_idx
//  Description : DEPTH x W synchronous FIFO with full/empty flags and
//                asynchronous active-high reset. Pointers carry one extra
//                wrap bit so full and empty are distinguished without a
//                separate occupancy counter. Read data is the current head.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_idx #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int C_AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [C_AW:0] wr_ptr_q;
    logic [C_AW:0] rd_ptr_q;
    logic          w_push;
    logic          w_pop;

    // Writes are refused while full, reads while empty
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i  && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[C_AW] != rd_ptr_q[C_AW]) &&
                     (wr_ptr_q[C_AW-1:0] == rd_ptr_q[C_AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[C_AW-1:0]];

    // Pointer registers; reset empties the FIFO immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (C_AW+1)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (C_AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q[C_AW-1:0]] <= data_i;
    end

endmodule : sync_fifo_idx
`default_nettype wire

// File: rtl/onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_pulse_decoder
//  Description : Accepts encoded line indices over valid/ready, buffers them
//                in a small FIFO and replays each one as a one-hot pulse of
//                PULSE_LEN cycles followed by GAP_LEN idle cycles.
//                Out-of-range indices are dropped and flagged (sticky).
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_pulse_decoder
    import onehot_pkg::*;
#(
    parameter int N         = C_ONEHOT_N,
    parameter int IDX_W     = C_ONEHOT_IDX_W,
    parameter int DEPTH     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IDX_W-1:0]        in_index,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N-1:0]            out_onehot,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    err_range,
    output logic [C_SENT_CNT_W-1:0] sent_count
);

    // Counter must hold the larger of PULSE_LEN-1 and GAP_LEN-1
    localparam int C_CNT_MAX = (PULSE_LEN > GAP_LEN) ?
                               ((PULSE_LEN > 2) ? PULSE_LEN : 2) :
                               ((GAP_LEN   > 2) ? GAP_LEN   : 2);
    localparam int C_CNT_W   = $clog2(C_CNT_MAX);

    localparam logic [C_CNT_W-1:0] C_PULSE_LOAD = C_CNT_W'(PULSE_LEN - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LOAD   =
        (GAP_LEN > 0) ? C_CNT_W'(GAP_LEN - 1) : '0;
    localparam logic [N-1:0]       C_ONE        = {{(N-1){1'b0}}, 1'b1};

    dec_state_e                state_q, state_d;
    logic [C_CNT_W-1:0]        cnt_q, cnt_d;
    logic [N-1:0]              onehot_q, onehot_d;
    logic [C_SENT_CNT_W-1:0]   sent_q, sent_d;
    logic                      err_q;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_accept;
    logic                      w_in_range;
    logic                      w_push;
    logic                      w_pop;
    logic [IDX_W-1:0]          w_head_idx;
    logic [N-1:0]              w_head_onehot;
    logic [31:0]               w_index_ext;

    // Handshake and range check; dropped indices still complete the handshake
    assign w_accept      = in_valid && !w_full;
    assign w_index_ext   = 32'(in_index);
    assign w_in_range    = (w_index_ext < 32'(N));
    assign w_push        = w_accept && w_in_range;
    assign w_head_onehot = C_ONE << w_head_idx;

    sync_fifo_idx #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (in_index),
        .pop_i   (w_pop),
        .data_o  (w_head_idx),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // State, counter, output and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            sent_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            sent_q   <= sent_d;
            if (w_accept && !w_in_range) err_q <= 1'b1;
        end
    end

    // Next-state logic: pulse load, hold, gap and back-to-back reload
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        sent_d   = sent_q;
        w_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    onehot_d = w_head_onehot;
                    cnt_d    = C_PULSE_LOAD;
                    sent_d   = sent_q + C_SENT_CNT_W'(1);
                    state_d  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end else if (GAP_LEN > 0) begin
                    onehot_d = '0;
                    cnt_d    = C_GAP_LOAD;
                    state_d  = ST_GAP;
                end else if (!w_empty) begin
                    // No gap configured: chain the next pulse without a zero cycle
                    w_pop    = 1'b1;
                    onehot_d = w_head_onehot;
                    cnt_d    = C_PULSE_LOAD;
                    sent_d   = sent_q + C_SENT_CNT_W'(1);
                end else begin
                    onehot_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                onehot_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Outputs are taken straight from registers; in_ready from FIFO pointers
    always_comb begin
        out_onehot = onehot_q;
        out_valid  = |onehot_q;
        busy       = (state_q != ST_IDLE) || !w_empty;
        in_ready   = !w_full;
        err_range  = err_q;
        sent_count = sent_q;
    end

endmodule : onehot_pulse_decoder
`default_nettype wire

// File: tb/tb_onehot_pulse_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_pulse_decoder
//  Description : Self-checking bench for onehot_pulse_decoder. Three
//                instances: defaults (A), PULSE_LEN=1/GAP_LEN=0 (B), N=6 (C).
//                Instance A is checked by a scoreboard queue of expected
//                pulses plus directed latency/reset checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_pulse_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: default parameters
    logic        a_rst, a_valid, a_ready, a_ovalid, a_busy, a_err;
    logic [2:0]  a_index;
    logic [7:0]  a_onehot;
    logic [15:0] a_sent;
    // Instance B: back-to-back pulses
    logic        b_rst, b_valid, b_ready, b_ovalid, b_busy, b_err;
    logic [2:0]  b_index;
    logic [7:0]  b_onehot;
    logic [15:0] b_sent;
    // Instance C: six lines, indices 6 and 7 out of range
    logic        c_rst, c_valid, c_ready, c_ovalid, c_busy, c_err;
    logic [2:0]  c_index;
    logic [5:0]  c_onehot;
    logic [15:0] c_sent;

    onehot_pulse_decoder u_a (
        .clk(clk), .rst(a_rst), .in_index(a_index), .in_valid(a_valid),
        .in_ready(a_ready), .out_onehot(a_onehot), .out_valid(a_ovalid),
        .busy(a_busy), .err_range(a_err), .sent_count(a_sent)
    );

    onehot_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_b (
        .clk(clk), .rst(b_rst), .in_index(b_index), .in_valid(b_valid),
        .in_ready(b_ready), .out_onehot(b_onehot), .out_valid(b_ovalid),
        .busy(b_busy), .err_range(b_err), .sent_count(b_sent)
    );

    onehot_pulse_decoder #(.N(6)) u_c (
        .clk(clk), .rst(c_rst), .in_index(c_index), .in_valid(c_valid),
        .in_ready(c_ready), .out_onehot(c_onehot), .out_valid(c_ovalid),
        .busy(c_busy), .err_range(c_err), .sent_count(c_sent)
    );

    logic [7:0] q_a [$];
    bit         saw_full;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference priority encoder: index of the highest set bit
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Highest set bit isolated by bit smearing
    function automatic logic [7:0] msb_mask(input logic [7:0] v);
        logic [7:0] s = v;
        s = s | (s >> 1);
        s = s | (s >> 2);
        s = s | (s >> 4);
        return s ^ (s >> 1);
    endfunction

    // Offer one index to A, holding it until accepted; expected pulse queued on accept
    task automatic send_a(input logic [2:0] idx, input logic [7:0] exp);
        int  n    = 0;
        bit  done = 1'b0;
        a_index = idx;
        a_valid = 1'b1;
        while (!done && n < 200) begin
            if (!a_ready) saw_full = 1'b1;
            done = a_ready;
            if (done) q_a.push_back(exp);
            step();
            n++;
        end
        if (!done) chk("send_a_timeout", 32'd0, 32'd1);
        a_valid = 1'b0;
    endtask

    // Wait until every expected pulse has appeared and A is idle
    task automatic drain_a(input string tag);
        int n = 0;
        while ((q_a.size() != 0 || a_busy) && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_drain_in_time"}, 32'(n < 2000), 32'd1);
        chk({tag, "_queue_empty"}, 32'(q_a.size()), 32'd0);
    endtask

    // Scoreboard monitor for A: pulse value, pulse length, gap length
    logic [7:0] m_prev;
    int         m_run;
    int         m_zero;
    bit         m_in_gap;
    logic [7:0] m_exp;
    always @(negedge clk) begin
        if (a_rst) begin
            m_prev   = '0;
            m_run    = 0;
            m_zero   = 0;
            m_in_gap = 1'b0;
        end else begin
            chk("a_out_valid", 32'(a_ovalid), 32'(a_onehot != 8'h00));
            if (a_onehot != 8'h00) begin
                if (m_prev == 8'h00) begin
                    if (m_in_gap) chk("a_gap_len", 32'(m_zero), 32'd2);
                    m_in_gap = 1'b0;
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_pulse", 32'(a_onehot), 32'd0);
                    end else begin
                        m_exp = q_a.pop_front();
                        chk("a_pulse_value", 32'(a_onehot), 32'(m_exp));
                    end
                    m_run = 1;
                end else begin
                    chk("a_pulse_stable", 32'(a_onehot), 32'(m_prev));
                    m_run++;
                end
            end else begin
                if (m_prev != 8'h00) begin
                    chk("a_pulse_len", 32'(m_run), 32'd2);
                    m_in_gap = 1'b1;
                    m_zero   = 0;
                end
                if (m_in_gap) begin
                    if (a_busy) m_zero++;
                    else        m_in_gap = 1'b0;
                end
            end
            m_prev = a_onehot;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vals [6];
        logic [7:0] vec;
        vals = '{8'd0, 8'd7, 8'd7, 8'd1, 8'd2, 8'd4};
        saw_full = 1'b0;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        a_index = '0;  b_index = '0;  c_index = '0;
        step();
        step();

        // Reset state
        chk("rst_onehot",   32'(a_onehot), 32'd0);
        chk("rst_out_valid",32'(a_ovalid), 32'd0);
        chk("rst_busy",     32'(a_busy),   32'd0);
        chk("rst_err",      32'(a_err),    32'd0);
        chk("rst_sent",     32'(a_sent),   32'd0);
        chk("rst_ready",    32'(a_ready),  32'd1);
        chk("rst_ready_c",  32'(c_ready),  32'd1);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        step();

        // Single index 3: latency one edge, held two cycles, gap, then idle
        q_a.push_back(8'h08);
        a_index = 3'd3; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("t1_before_pulse", 32'(a_onehot), 32'd0);
        chk("t1_busy_queued",  32'(a_busy),   32'd1);
        step();
        chk("t1_pulse_c1", 32'(a_onehot), 32'h08);
        chk("t1_sent",     32'(a_sent),   32'd1);
        step();
        chk("t1_pulse_c2", 32'(a_onehot), 32'h08);
        step();
        chk("t1_gap",      32'(a_onehot), 32'd0);
        chk("t1_busy_gap", 32'(a_busy),   32'd1);
        step();
        chk("t1_idle_busy", 32'(a_busy),  32'd0);
        chk("t1_sent_end",  32'(a_sent),  32'd1);

        // Reset applied during the second pulse cycle of index 5
        q_a.push_back(8'h20);
        a_index = 3'd5; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        chk("mr_pulse_c1", 32'(a_onehot), 32'h20);
        step();
        chk("mr_pulse_c2", 32'(a_onehot), 32'h20);
        #2 a_rst = 1'b1;
        #1;
        chk("mr_onehot", 32'(a_onehot), 32'd0);
        chk("mr_valid",  32'(a_ovalid), 32'd0);
        chk("mr_sent",   32'(a_sent),   32'd0);
        chk("mr_ready",  32'(a_ready),  32'd1);
        chk("mr_busy",   32'(a_busy),   32'd0);
        step();
        chk("mr_ready_held", 32'(a_ready), 32'd1);
        a_rst = 1'b0;
        step();

        // Burst of six indices offered every cycle; FIFO must fill
        for (int i = 0; i < 6; i++) send_a(vals[i][2:0], msb_mask(8'd1 << vals[i][2:0]));
        drain_a("burst");
        chk("burst_saw_full", 32'(saw_full), 32'd1);
        chk("burst_sent",     32'(a_sent),   32'd6);

        // Back-to-back: PULSE_LEN=1, GAP_LEN=0, indices 2 then 6
        b_index = 3'd2; b_valid = 1'b1;
        step();
        b_index = 3'd6;
        chk("b2b_before", 32'(b_onehot), 32'd0);
        step();
        b_valid = 1'b0;
        chk("b2b_first",  32'(b_onehot), 32'h04);
        step();
        chk("b2b_second", 32'(b_onehot), 32'h40);
        step();
        chk("b2b_after",  32'(b_onehot), 32'd0);
        chk("b2b_sent",   32'(b_sent),   32'd2);
        chk("b2b_busy",   32'(b_busy),   32'd0);

        // N=6: indices 6 and 7 dropped with handshake, then 1 pulses
        c_index = 3'd6; c_valid = 1'b1;
        chk("rng_ready_6", 32'(c_ready), 32'd1);
        step();
        chk("rng_err_6",   32'(c_err),   32'd1);
        chk("rng_busy_6",  32'(c_busy),  32'd0);
        c_index = 3'd7;
        chk("rng_ready_7", 32'(c_ready), 32'd1);
        step();
        chk("rng_err_7",   32'(c_err),   32'd1);
        chk("rng_busy_7",  32'(c_busy),  32'd0);
        c_index = 3'd1;
        step();
        c_valid = 1'b0;
        chk("rng_before",  32'(c_onehot), 32'd0);
        step();
        chk("rng_pulse_c1", 32'(c_onehot), 32'h02);
        step();
        chk("rng_pulse_c2", 32'(c_onehot), 32'h02);
        step();
        chk("rng_gap",     32'(c_onehot), 32'd0);
        step();
        chk("rng_sent",    32'(c_sent),   32'd1);
        chk("rng_err_sticky", 32'(c_err), 32'd1);
        chk("rng_busy_end", 32'(c_busy),  32'd0);

        // Encoder-to-decoder loop: first vector A0h, then random non-zero vectors
        for (int i = 0; i < 1000; i++) begin
            vec = (i == 0) ? 8'hA0 : 8'($urandom_range(1, 255));
            send_a(enc(vec), msb_mask(vec));
        end
        drain_a("enc_loop");
        chk("enc_loop_sent", 32'(a_sent), 32'd1006);
        chk("enc_loop_err",  32'(a_err),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_onehot_pulse_decoder
`default_nettype wire
